// File: rtl/scan_sel_gen.sv
// scan_sel_gen: masked position scanner with per-position dwell, tick and frame-wrap pulses
module scan_sel_gen #(
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_dir,
  input  logic [7:0]         i_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [2:0]         o_sel,
  output logic               o_valid,
  output logic               o_tick,
  output logic               o_wrap
);
  typedef enum logic {IDLE, DWELL} state_t;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d, base, cand, nxt;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d, wrap_q, wrap_d, run, adv, load;
  // state and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end
  // nearest set mask bit after base in scan direction; starting from 7 (asc) or 0 (desc) yields the first position
  always_comb begin
    base = (state_q == IDLE) ? {3{~i_dir}} : sel_q;
    nxt  = base;
    cand = base;
    for (int k = 8; k >= 1; k--) begin
      cand = i_dir ? base - 3'(k) : base + 3'(k);
      nxt  = i_mask[cand] ? cand : nxt;
    end
  end
  // next state: disable or empty mask wins over advance; advance on dwell expiry or cleared current bit
  always_comb begin
    run     = i_en & |i_mask;
    adv     = (cnt_q >= i_dwell) | ~i_mask[sel_q];
    load    = run & ((state_q == IDLE) | adv);
    state_d = run ? DWELL : IDLE;
    sel_d   = load ? nxt : sel_q;
    cnt_d   = (run & (state_q == DWELL) & ~adv) ? cnt_q + 1'b1 : '0;
    tick_d  = load;
    wrap_d  = run & (state_q == DWELL) & adv & (i_dir ? nxt >= sel_q : nxt <= sel_q);
  end
  // outputs; valid tracks the live mask so a cleared bit drops it immediately
  always_comb begin
    o_sel   = sel_q;
    o_valid = (state_q == DWELL) & i_mask[sel_q];
    o_tick  = tick_q;
    o_wrap  = wrap_q;
  end
endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen: scoreboard bench for scan_sel_gen
module tb_scan_sel_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, dir = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [15:0] dwell = 16'd0;
  logic [2:0] sel;
  logic valid, tick, wrap;
  int errors = 0, checks = 0;
  logic [5:0] sbq[$];
  logic [5:0] exp_v;
  bit m_st = 1'b0;
  logic [2:0] m_sel = 3'd0;
  int m_cnt = 0;

  scan_sel_gen #(.DWELL_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_mask(mask), .i_dwell(dwell),
    .o_sel(sel), .o_valid(valid), .o_tick(tick), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    logic [2:0] p;
    bit tk, wr;
    tk = 1'b0;
    wr = 1'b0;
    if (rst) begin
      m_st = 1'b0; m_sel = 3'd0; m_cnt = 0;
    end else if (!en || mask == 8'h00) begin
      m_st = 1'b0; m_cnt = 0;
    end else if (!m_st) begin
      p = dir ? 3'd7 : 3'd0;
      while (!mask[p]) p = dir ? p - 3'd1 : p + 3'd1;
      m_sel = p; m_st = 1'b1; m_cnt = 0; tk = 1'b1;
    end else if (m_cnt >= int'(dwell) || !mask[m_sel]) begin
      p = m_sel;
      do p = dir ? p - 3'd1 : p + 3'd1; while (!mask[p]);
      wr = dir ? (p >= m_sel) : (p <= m_sel);
      m_sel = p; m_cnt = 0; tk = 1'b1;
    end else begin
      m_cnt++;
    end
    sbq.push_back({m_sel, m_st & mask[m_sel], tk, wr});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    void'(sbq.pop_front());
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mask = 8'hFF;
    cycle();
    exp_v = sbq.pop_front();
    checks++;
    if ({sel, valid, tick, wrap} !== exp_v) begin
      errors++; $display("FAIL reset_sb got %b exp %b", {sel, valid, tick, wrap}, exp_v);
    end
    checks++;
    if ({sel, valid, tick, wrap} !== 6'b000_0_0_0) begin
      errors++; $display("FAIL reset_state got %b exp 000000", {sel, valid, tick, wrap});
    end
  endtask

  task automatic test_ascending();
    do_reset();
    en = 1'b1; mask = 8'hFF; dir = 1'b0; dwell = 16'd2;
    for (int i = 0; i < 27; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL asc_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
      checks++;
      if (sel !== 3'((i / 3) % 8) || tick !== (i % 3 == 0) || wrap !== (i % 3 == 0 && i > 0 && (i / 3) % 8 == 0) || valid !== 1'b1) begin
        errors++; $display("FAIL asc_seq i=%0d got sel=%0d tick=%b wrap=%b valid=%b exp sel=%0d", i, sel, tick, wrap, valid, (i / 3) % 8);
      end
    end
  endtask

  task automatic test_sparse_desc();
    logic [2:0] seq [3];
    seq = '{3'd7, 3'd5, 3'd2};
    do_reset();
    en = 1'b1; mask = 8'b1010_0100; dir = 1'b1; dwell = 16'd0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL desc_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
      checks++;
      if (sel !== seq[i % 3] || tick !== 1'b1 || wrap !== (i > 0 && i % 3 == 0)) begin
        errors++; $display("FAIL desc_seq i=%0d got sel=%0d tick=%b wrap=%b exp sel=%0d", i, sel, tick, wrap, seq[i % 3]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; mask = 8'h10; dir = 1'b0; dwell = 16'd1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL single_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
      checks++;
      if (sel !== 3'd4 || valid !== 1'b1 || tick !== (i % 2 == 0) || wrap !== (i > 0 && i % 2 == 0)) begin
        errors++; $display("FAIL single_seq i=%0d got sel=%0d valid=%b tick=%b wrap=%b exp sel=4", i, sel, valid, tick, wrap);
      end
    end
  endtask

  task automatic test_forced_adv();
    do_reset();
    en = 1'b1; mask = 8'hFF; dir = 1'b0; dwell = 16'd0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL fadv_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
    end
    dwell = 16'd100;
    for (int i = 0; i < 10; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL fadv_hold_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
    end
    checks++;
    if (sel !== 3'd3 || tick !== 1'b0 || valid !== 1'b1) begin
      errors++; $display("FAIL fadv_pre got sel=%0d tick=%b valid=%b exp sel=3 tick=0 valid=1", sel, tick, valid);
    end
    mask = 8'hF7;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL fadv_valid_drop got %b exp 0", valid);
    end
    cycle();
    exp_v = sbq.pop_front();
    checks++;
    if ({sel, valid, tick, wrap} !== exp_v || {sel, valid, tick, wrap} !== 6'b100_1_1_0) begin
      errors++; $display("FAIL fadv_step got %b exp %b", {sel, valid, tick, wrap}, 6'b100_1_1_0);
    end
    en = 1'b0;
    cycle();
    exp_v = sbq.pop_front();
    checks++;
    if ({sel, valid, tick, wrap} !== exp_v || {sel, valid, tick, wrap} !== 6'b100_0_0_0) begin
      errors++; $display("FAIL fadv_disable got %b exp %b", {sel, valid, tick, wrap}, 6'b100_0_0_0);
    end
  endtask

  task automatic test_dwell_live();
    do_reset();
    en = 1'b1; mask = 8'hFF; dir = 1'b0; dwell = 16'd100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL live_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
    end
    dwell = 16'd2; dir = 1'b1;
    cycle();
    exp_v = sbq.pop_front();
    checks++;
    if ({sel, valid, tick, wrap} !== exp_v || {sel, valid, tick, wrap} !== 6'b111_1_1_1) begin
      errors++; $display("FAIL live_lower got %b exp %b", {sel, valid, tick, wrap}, 6'b111_1_1_1);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    do_reset();
    en = 1'b1; mask = 8'hFF; dir = 1'b0; dwell = 16'd1;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL rmid_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
      found = (m_sel == 3'd5);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rmid_timeout got no sel=5 exp sel=5 within 40 cycles");
    end
    rst = 1'b1;
    cycle();
    exp_v = sbq.pop_front();
    checks++;
    if ({sel, valid, tick, wrap} !== exp_v || {sel, valid, tick, wrap} !== 6'b000_0_0_0) begin
      errors++; $display("FAIL rmid_reset got %b exp 000000", {sel, valid, tick, wrap});
    end
    rst = 1'b0; mask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v || {sel, valid, tick, wrap} !== 6'b000_0_0_0) begin
        errors++; $display("FAIL rmid_empty i=%0d got %b exp 000000", i, {sel, valid, tick, wrap});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(49) == 0);
      en = ($urandom_range(15) != 0);
      if ($urandom_range(3) == 0) mask = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(7) == 0) dir = ~dir;
      if ($urandom_range(5) == 0) dwell = 16'($urandom_range(3));
      cycle();
      exp_v = sbq.pop_front();
      checks++;
      if ({sel, valid, tick, wrap} !== exp_v) begin
        errors++; $display("FAIL rand_sb i=%0d got %b exp %b", i, {sel, valid, tick, wrap}, exp_v);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ascending();
    test_sparse_desc();
    test_single();
    test_forced_adv();
    test_dwell_live();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
